pe_array_ctrl: RTL and testbench

- Sequencer for an ARRAY_N x ARRAY_N systolic array of 16-bit Q2.13 multiply-accumulate PEs in the MHA datapath.
- Per tile it:
  - loads one weight row per cycle into the array,
  - streams I_K_LEN X vectors from the X buffer into row 0,
  - skews the X-valid down the rows,
  - drains the pipeline, generating per-column output-capture strobes.
- Sits between the attention top-level FSM (start/done) and the PE array plus its weight and X buffers.

---
 rtl/pe_array_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pe_array_ctrl
// Description : Tile sequencer for an ARRAY_N x ARRAY_N systolic MAC array.
//               Loads weight rows, streams X vectors into row 0, skews the
//               X-valid down the rows, and produces per-column capture
//               strobes while the array pipeline drains.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_array_ctrl #(
   parameter int ARRAY_N  = 8,
   parameter int PIPE_LAT = 16,
   parameter int K_W      = 8
) (
   input  logic                       I_CLK,
   input  logic                       I_RST,
   input  logic                       I_START,
   input  logic [K_W-1:0]             I_K_LEN,
   input  logic                       I_X_RDY,
   output logic                       O_W_LD,
   output logic [$clog2(ARRAY_N)-1:0] O_W_ROW,
   output logic                       O_X_RD_EN,
   output logic [K_W-1:0]             O_X_RD_ADDR,
   output logic [ARRAY_N-1:0]         O_ROW_VLD,
   output logic [ARRAY_N-1:0]         O_COL_CAP,
   output logic                       O_BUSY,
   output logic                       O_DONE
);

   localparam int ROW_W     = $clog2(ARRAY_N);
   localparam int DRAIN_LEN = PIPE_LAT + ARRAY_N;
   localparam int DRN_W     = $clog2(DRAIN_LEN + 1);
   // Delay line tap i holds ROW_VLD[0] delayed i+1 cycles.
   localparam int CAP_LEN   = PIPE_LAT + ARRAY_N - 1;

   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ARRAY_N - 1);
   localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(DRAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_FEED   = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [ROW_W-1:0]     load_cnt;
   logic [K_W-1:0]       feed_cnt;
   logic [DRN_W-1:0]     drain_cnt;
   logic [K_W-1:0]       k_len;
   logic [ARRAY_N-1:0]   row_vld;
   logic [CAP_LEN-1:0]   cap_sr;
   logic                 rd_en;
   logic                 w_ld;
   logic                 busy;
   logic                 done;

   // State register.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived outputs; the X read enable follows
   // I_X_RDY directly so a stalled buffer never gets a read.
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      w_ld      = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (I_START) begin
               state_nxt = S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            w_ld = 1'b1;
            if (load_cnt == LAST_ROW) begin
               state_nxt = (k_len == '0) ? S_DRAIN : S_FEED;
            end
         end
         S_FEED: begin
            rd_en = I_X_RDY;
            if (I_X_RDY && (feed_cnt == (k_len - K_W'(1)))) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == LAST_DRAIN) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Tile counters and latched vector count; the feed count is cleared at
   // start so it reads 0 on the first FEED cycle.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         k_len     <= '0;
         load_cnt  <= '0;
         feed_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if ((state == S_IDLE) && I_START) begin
            k_len    <= I_K_LEN;
            feed_cnt <= '0;
         end else if (rd_en) begin
            feed_cnt <= feed_cnt + K_W'(1);
         end

         if (state == S_LOAD_W) begin
            load_cnt <= (load_cnt == LAST_ROW) ? '0 : load_cnt + ROW_W'(1);
         end else begin
            load_cnt <= '0;
         end

         if (state == S_DRAIN) begin
            drain_cnt <= (drain_cnt == LAST_DRAIN) ? '0 : drain_cnt + DRN_W'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // Row-valid skew and capture delay line; both shift every cycle so any
   // strobes still in flight finish after the FSM has moved on.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         row_vld <= '0;
         cap_sr  <= '0;
      end else begin
         row_vld <= {row_vld[ARRAY_N-2:0], rd_en};
         cap_sr  <= {cap_sr[CAP_LEN-2:0], row_vld[0]};
      end
   end

   assign O_W_LD      = w_ld;
   assign O_W_ROW     = load_cnt;
   assign O_X_RD_EN   = rd_en;
   assign O_X_RD_ADDR = feed_cnt;
   assign O_ROW_VLD   = row_vld;
   // Column c taps ROW_VLD[0] delayed PIPE_LAT+c cycles.
   assign O_COL_CAP   = cap_sr[CAP_LEN-1:PIPE_LAT-1];
   assign O_BUSY      = busy;
   assign O_DONE      = done;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_array_ctrl
// Description : Scoreboard bench for pe_array_ctrl (ARRAY_N=4, PIPE_LAT=8).
//               A tile-level model predicts every output event with its
//               cycle; a monitor compares the DUT against those queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_array_ctrl;

   localparam int N     = 4;
   localparam int PL    = 8;
   localparam int KW    = 8;
   localparam int NCH   = 3 + 2 * N;
   localparam int TABSZ = 8192;
   localparam int CH_W  = 0;
   localparam int CH_RD = 1;
   localparam int CH_DN = 2;
   localparam int CH_RV = 3;
   localparam int CH_CC = 3 + N;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_len;
   logic          x_rdy;
   logic          w_ld;
   logic [1:0]    w_row;
   logic          x_rd_en;
   logic [KW-1:0] x_rd_addr;
   logic [N-1:0]  row_vld;
   logic [N-1:0]  col_cap;
   logic          busy;
   logic          done;

   pe_array_ctrl #(.ARRAY_N(N), .PIPE_LAT(PL), .K_W(KW)) dut (
      .I_CLK       (clk),
      .I_RST       (rst),
      .I_START     (start),
      .I_K_LEN     (k_len),
      .I_X_RDY     (x_rdy),
      .O_W_LD      (w_ld),
      .O_W_ROW     (w_row),
      .O_X_RD_EN   (x_rd_en),
      .O_X_RD_ADDR (x_rd_addr),
      .O_ROW_VLD   (row_vld),
      .O_COL_CAP   (col_cap),
      .O_BUSY      (busy),
      .O_DONE      (done)
   );

   always #5 clk = ~clk;

   // cyc counts rising edges; the value seen between edges labels the cycle
   // whose closing edge has that index.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   ev_t evq[NCH][$];
   bit  rdy_tab[TABSZ];

   int  n_checks  = 0;
   int  n_pass    = 0;
   int  next_idle = 0;
   int  cur_s     = 0;
   int  cur_done  = 0;
   bit  cur_valid = 1'b0;

   function automatic void push_ev(int ch, int c, int v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      evq[ch].push_back(e);
   endfunction

   // Tile model: weights in the N cycles after start, then one read per
   // ready cycle; each read's valid reaches row r r+1 cycles later and
   // column c's capture PL+c+1 cycles later; drain is PL+N cycles after the
   // last read (or after loading when k=0), then one done cycle.
   function automatic void launch(int s, int k);
      int t;
      int j;
      int last;
      for (int i = 0; i < N; i++) push_ev(CH_W, s + 1 + i, i);
      t    = s + N + 1;
      j    = 0;
      last = s + N;
      while (j < k && t < s + TABSZ) begin
         if (rdy_tab[t % TABSZ]) begin
            push_ev(CH_RD, t, j);
            for (int r = 0; r < N; r++) push_ev(CH_RV + r, t + 1 + r, 0);
            for (int c = 0; c < N; c++) push_ev(CH_CC + c, t + 1 + PL + c, 0);
            j++;
            last = t;
         end
         t++;
      end
      cur_s     = s;
      cur_done  = last + 1 + PL + N;
      cur_valid = 1'b1;
      push_ev(CH_DN, cur_done, 0);
      next_idle = cur_done + 1;
   endfunction

   function automatic void flush(int t);
      for (int ch = 0; ch < NCH; ch++) begin
         while (evq[ch].size() > 0 && evq[ch][evq[ch].size()-1].cyc >= t)
            void'(evq[ch].pop_back());
      end
   endfunction

   // Drive one cycle's inputs just after the falling edge.
   task automatic drive(input bit st, input int k, input bit rs);
      @(negedge clk);
      rst   = rs;
      start = st;
      k_len = k[KW-1:0];
      x_rdy = rdy_tab[cyc % TABSZ];
      if (rs) begin
         flush(cyc);
         cur_valid = 1'b0;
         next_idle = 0;
      end else if (st && cyc >= next_idle) begin
         launch(cyc, k);
      end
   endtask

   task automatic idle_wait();
      for (int i = 0; i < 4000 && cyc < next_idle + 1; i++) drive(1'b0, 0, 1'b0);
   endtask

   task automatic check_ch(input int ch, input bit obs, input int val, input int t,
                           input string name);
      bit exp;
      int rv;
      while (evq[ch].size() > 0 && evq[ch][0].cyc < t) begin
         n_checks++;
         $display("FAIL %s: event due at cycle %0d (val %0d) never seen",
                  name, evq[ch][0].cyc, evq[ch][0].val);
         void'(evq[ch].pop_front());
      end
      exp = (evq[ch].size() > 0) && (evq[ch][0].cyc == t);
      rv  = exp ? evq[ch][0].val : -1;
      if (obs || exp) begin
         n_checks++;
         if (obs && exp && rv == val) n_pass++;
         else $display("FAIL %s cycle %0d: got present=%0b val=%0d, required present=%0b val=%0d",
                       name, t, obs, val, exp, rv);
         if (exp) void'(evq[ch].pop_front());
      end
   endtask

   // Monitor: samples 1 time unit after each falling edge.
   initial begin
      int  t;
      bit  exp_busy;
      forever begin
         @(negedge clk);
         #1;
         t = cyc;
         if (rst) begin
            n_checks++;
            if ({w_ld, w_row, x_rd_en, x_rd_addr, row_vld, col_cap, busy, done} == '0)
               n_pass++;
            else
               $display("FAIL reset_outputs cycle %0d: got w_ld=%0b row_vld=%h col_cap=%h busy=%0b done=%0b, required all 0",
                        t, w_ld, row_vld, col_cap, busy, done);
         end else begin
            exp_busy = cur_valid && (t > cur_s) && (t <= cur_done);
            n_checks++;
            if (busy == exp_busy) n_pass++;
            else $display("FAIL busy cycle %0d: got %0b, required %0b", t, busy, exp_busy);
            check_ch(CH_W, w_ld, int'(w_row), t, "w_ld");
            check_ch(CH_RD, x_rd_en, int'(x_rd_addr), t, "x_rd");
            check_ch(CH_DN, done, 0, t, "done");
            for (int r = 0; r < N; r++)
               check_ch(CH_RV + r, row_vld[r], 0, t, $sformatf("row_vld[%0d]", r));
            for (int c = 0; c < N; c++)
               check_ch(CH_CC + c, col_cap[c], 0, t, $sformatf("col_cap[%0d]", c));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int sel;
      rst   = 1'b1;
      start = 1'b0;
      k_len = '0;
      x_rdy = 1'b0;
      for (int i = 0; i < TABSZ; i++) rdy_tab[i] = 1'b1;

      repeat (3) drive(1'b0, 0, 1'b1);
      repeat (2) drive(1'b0, 0, 1'b0);

      // Nominal tile, K=3.
      drive(1'b1, 3, 1'b0);
      idle_wait();

      // Single-cycle stall on the second feed cycle (start+6).
      rdy_tab[(cyc + 7) % TABSZ] = 1'b0;
      drive(1'b1, 3, 1'b0);
      idle_wait();
      for (int i = 0; i < TABSZ; i++) rdy_tab[i] = 1'b1;

      // Empty tile.
      drive(1'b1, 0, 1'b0);
      idle_wait();

      // Start held high across a whole tile and into the next.
      repeat (26) drive(1'b1, 3, 1'b0);
      idle_wait();

      // Reset during FEED, then a clean tile.
      drive(1'b1, 3, 1'b0);
      repeat (5) drive(1'b0, 0, 1'b0);
      repeat (3) drive(1'b0, 0, 1'b1);
      drive(1'b0, 0, 1'b0);
      drive(1'b1, 3, 1'b0);
      idle_wait();

      // Longest tile.
      drive(1'b1, 255, 1'b0);
      idle_wait();

      // Randomized tiles with random stalls and spurious start pulses.
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 300; i++)
            rdy_tab[(cyc + i) % TABSZ] = ($urandom_range(0, 3) != 0);
         sel = $urandom_range(0, 9);
         if (sel == 0)     k = 0;
         else if (sel < 8) k = $urandom_range(1, 12);
         else              k = $urandom_range(13, 60);
         drive(1'b1, k, 1'b0);
         for (int i = 0; i < 4000 && cyc < next_idle + 1; i++)
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 255), 1'b0);
         repeat ($urandom_range(0, 3)) drive(1'b0, 0, 1'b0);
      end

      repeat (3) drive(1'b0, 0, 1'b0);
      #3;
      for (int ch = 0; ch < NCH; ch++) begin
         while (evq[ch].size() > 0) begin
            n_checks++;
            $display("FAIL channel %0d: event due at cycle %0d never seen", ch, evq[ch][0].cyc);
            void'(evq[ch].pop_front());
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
